// File: rtl/pressure_sequencer.sv
// Timed pressurize/depressurize sequencer: IDLE -> PRESS|DEPRESS for D cycles -> DONE pulse.
// Define PRESS_ABORT_EN to add the abort input and aborted pulse output.
module pressure_sequencer #(
  parameter int DUR_W           = 8,
  parameter int DEPRESS_EN_MODE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [DUR_W-1:0] duration,
`ifdef PRESS_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             pressurizing,
  output logic             depressurizing,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESS   = 2'd1;
  localparam logic [1:0] DEPRESS = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             eff_mode;
  logic             press_q, depress_q, busy_q, done_q;
`ifdef PRESS_ABORT_EN
  logic             abort_hit_d;
  logic             aborted_q;
`endif

  // A pressurize-only build treats every request as pressurize.
  assign eff_mode = (DEPRESS_EN_MODE != 0) ? mode : 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
`ifdef PRESS_ABORT_EN
    abort_hit_d = 1'b0;
`endif
    case (state_q)
      PRESS, DEPRESS: begin
`ifdef PRESS_ABORT_EN
        if (abort) begin
          state_d     = IDLE;
          abort_hit_d = 1'b1;
        end else
`endif
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          mode_d = eff_mode;
          // Counter holds D-1 so the phase lasts exactly D cycles without needing D itself.
          if (duration == '0) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d   = duration - DUR_W'(1);
            state_d = eff_mode ? PRESS : DEPRESS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      press_q   <= 1'b0;
      depress_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PRESS_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      press_q   <= (state_d == PRESS);
      depress_q <= (state_d == DEPRESS);
      busy_q    <= (state_d == PRESS) || (state_d == DEPRESS);
      done_q    <= (state_d == DONE);
`ifdef PRESS_ABORT_EN
      aborted_q <= abort_hit_d;
`endif
    end
  end

  assign pressurizing   = press_q;
  assign depressurizing = depress_q;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef PRESS_ABORT_EN
  assign aborted        = aborted_q;
`endif

endmodule

// File: doc/pressure_sequencer.md
PRESSURE_SEQUENCER -- requirements
Module: pressure_sequencer

Interface
REQ-001 Parameter DUR_W, default 8: width of the duration operand and internal down-counter, legal range 2..16.
REQ-002 Parameter DEPRESS_EN_MODE, default 1: 1 enables depressurize mode; 0 makes the block pressurize-only.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a cycle, sampled on the rising clock edge.
REQ-006 mode  input  1  sampled with start: 1 = pressurize, 0 = depressurize.
REQ-007 duration  input  DUR_W  active-phase length in clock cycles, sampled with start.
REQ-008 pressurizing  output  1  high while the pressurize phase is active.
REQ-009 depressurizing  output  1  high while the depressurize phase is active.
REQ-010 busy  output  1  high in any active phase.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 abort  input  1  cancel request; port exists only with PRESS_ABORT_EN.
REQ-013 aborted  output  1  one-cycle pulse on cancel; port exists only with PRESS_ABORT_EN.

Function
REQ-014 States SHALL be IDLE, PRESS, DEPRESS and DONE, with all outputs registered.
REQ-015 In IDLE or DONE, start=1 at an edge with duration=D>0 SHALL load the counter with D-1, latch mode, and enter PRESS (mode=1) or DEPRESS (mode=0).
REQ-016 With DEPRESS_EN_MODE=0, mode SHALL be ignored and every accepted start SHALL enter PRESS.
REQ-017 In PRESS or DEPRESS, the counter SHALL decrement each edge; at the edge where it equals 0 the block SHALL enter DONE, so the active output is high for exactly D cycles.
REQ-018 pressurizing SHALL be 1 only in PRESS, depressurizing only in DEPRESS, and busy in either.
REQ-019 pressurizing and depressurizing SHALL never both be 1.
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL go to IDLE on the next edge unless a new start is accepted there.
REQ-021 start SHALL be ignored while busy=1; it SHALL neither restart nor extend the phase, nor change mode or duration.
REQ-022 start with duration=0 SHALL enter DONE directly: done pulses one cycle later with no active phase.
REQ-023 duration=2^DUR_W-1 SHALL give 2^DUR_W-1 active cycles with no counter wrap.
REQ-024 start held continuously SHALL re-trigger from DONE, giving a one-cycle done gap between back-to-back phases.

Reset
REQ-025 reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, latched mode 0, and drive pressurizing, depressurizing, busy, done and aborted to 0.
REQ-026 reset asserted mid-phase SHALL terminate the phase with no done or aborted pulse.
REQ-027 The first edge after reset release SHALL be able to accept start.

Configuration
REQ-028 Macro PRESS_ABORT_EN defined: the abort and aborted ports SHALL exist.
REQ-029 With PRESS_ABORT_EN, abort=1 at an edge in PRESS or DEPRESS SHALL enter IDLE, drop the active output and busy next cycle, pulse aborted for one cycle, and suppress done.
REQ-030 With PRESS_ABORT_EN, abort SHALL take priority over counter expiry at the same edge.
REQ-031 With PRESS_ABORT_EN, abort in IDLE or DONE SHALL have no effect, and start SHALL still be accepted at that edge.
REQ-032 Macro PRESS_ABORT_EN undefined: the abort and aborted ports and logic SHALL be absent, and a phase SHALL end only by expiry or reset.

Verification (DUR_W=8)
REQ-033 Reset check: reset=0 mid-PRESS with duration=10, asserted between clock edges -> all outputs 0 before the next edge, and no done pulse.
REQ-034 Pressurize phase: start=1, mode=1, duration=3 at edge k -> pressurizing=1 and busy=1 for cycles k+1..k+3, done=1 in cycle k+4 only.
REQ-035 Start ignored while busy: start with mode=1, duration=5, then start with mode=0, duration=9 re-pulsed at the third active cycle -> pressurizing stays exactly 5 cycles and depressurizing stays 0.
REQ-036 Boundary durations: duration=0 -> done pulse with busy never 1; duration=255 -> 255 active cycles, then done.
REQ-037 Back-to-back and mode-off: start held high with mode=0, duration=2 -> pattern of 2 depressurizing cycles then 1 done cycle, repeating; with DEPRESS_EN_MODE=0 the same stimulus gives pressurizing instead.
REQ-038 PRESS_ABORT_EN build: abort at the second cycle of a duration=6 phase -> aborted pulse next cycle and no done; abort coincident with the final count -> aborted pulse and no done.
